// File: rtl/serial_sequence_framer.sv
// Serial framer: emits SYNC_PATTERN, the payload MSB first, then guard zeros, one bit per clock.
// Feeds the downstream 1011 sequence detector; guard zeros let it return to idle between frames.
module serial_sequence_framer #(
  parameter int unsigned DATA_W       = 8,
  parameter logic [3:0]  SYNC_PATTERN = 4'b1011,
  parameter int unsigned GUARD_BITS   = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              sequence_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int unsigned MaxSeg = (DATA_W > GUARD_BITS) ?
                                   ((DATA_W > 4) ? DATA_W : 4) :
                                   ((GUARD_BITS > 4) ? GUARD_BITS : 4);
  localparam int unsigned BitCntW = $clog2(MaxSeg + 1);
  localparam int unsigned ShiftW  = DATA_W + 4;

  localparam logic [BitCntW-1:0] SyncLast    = BitCntW'(3);
  localparam logic [BitCntW-1:0] PayloadLast = BitCntW'(DATA_W - 1);
  localparam logic [BitCntW-1:0] GuardLast   = BitCntW'(GUARD_BITS - 1);

  typedef enum logic [1:0] {StIdle, StSync, StPayload, StGuard} state_e;

  state_e               state_q, state_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ShiftW-1:0]    shift_q, shift_d;
  logic                 sequence_out_q, sequence_out_d;
  logic                 bit_valid_q, bit_valid_d;
  logic [CNT_W-1:0]     frame_count_q, frame_count_d;

  // state_q/bit_cnt_q describe the bit currently on the line; *_d selects the next one.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q + BitCntW'(1);
    shift_d        = shift_q;
    sequence_out_d = 1'b0;
    bit_valid_d    = 1'b1;
    frame_count_d  = frame_count_q;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d   = '0;
        bit_valid_d = 1'b0;
        if (load_valid) begin
          state_d        = StSync;
          // Sync bit 3 goes straight to the line; the rest queue ahead of the payload.
          shift_d        = {SYNC_PATTERN[2:0], load_data, 1'b0};
          sequence_out_d = SYNC_PATTERN[3];
          bit_valid_d    = 1'b1;
        end
      end
      StSync: begin
        sequence_out_d = shift_q[ShiftW-1];
        shift_d        = shift_q << 1;
        if (bit_cnt_q == SyncLast) begin
          state_d   = StPayload;
          bit_cnt_d = '0;
        end
      end
      StPayload: begin
        if (bit_cnt_q == PayloadLast) begin
          state_d   = StGuard;
          bit_cnt_d = '0;
        end else begin
          sequence_out_d = shift_q[ShiftW-1];
          shift_d        = shift_q << 1;
        end
      end
      StGuard: begin
        if (bit_cnt_q == GuardLast) begin
          state_d       = StIdle;
          bit_cnt_d     = '0;
          bit_valid_d   = 1'b0;
          frame_count_d = frame_count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        bit_cnt_d   = '0;
        bit_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      sequence_out_q <= 1'b0;
      bit_valid_q    <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      sequence_out_q <= sequence_out_d;
      bit_valid_q    <= bit_valid_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign load_ready   = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign frame_done   = (state_q == StGuard) && (bit_cnt_q == GuardLast);
  assign sequence_out = sequence_out_q;
  assign bit_valid    = bit_valid_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_serial_sequence_framer.sv
// Scoreboard bench for serial_sequence_framer: a frame-level model queues expected line bits,
// a monitor pops and compares them; a second instance covers the DATA_W=1 / wrap corner.
module tb_serial_sequence_framer;

  localparam int DW = 8;
  localparam int GB = 2;
  localparam int L  = 4 + DW + GB;
  localparam logic [3:0] Sync = 4'b1011;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, sequence_out, bit_valid, busy, frame_done;
  logic [7:0]    frame_count;

  always #5 clock = ~clock;

  serial_sequence_framer #(
    .DATA_W(DW), .SYNC_PATTERN(Sync), .GUARD_BITS(GB), .CNT_W(8)
  ) u_dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sequence_out(sequence_out), .bit_valid(bit_valid),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic b;
    logic last;
    int   pos;
    logic zero;
  } exp_t;

  exp_t q[$];

  // Frame rule: sync bits 3..0, payload MSB first, then guard zeros.
  task automatic push_frame(input logic [DW-1:0] d);
    exp_t e;
    for (int k = 0; k < L; k++) begin
      if (k < 4)           e.b = Sync[3-k];
      else if (k < 4 + DW) e.b = d[DW-1-(k-4)];
      else                 e.b = 1'b0;
      e.last = (k == L - 1);
      e.pos  = k;
      e.zero = (d == '0);
      q.push_back(e);
    end
  endtask

  // Monitor: owns the queue pops, the completed-frame model count and a behavioural 1011 detector.
  logic [7:0] model_count = '0;
  logic       prev_done = 1'b0;
  logic [3:0] hist = '0;
  exp_t       mon_e;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      model_count = '0;
      prev_done   = 1'b0;
      hist        = '0;
    end else begin
      if (prev_done) check("frame_count", frame_count, model_count);
      prev_done = 1'b0;
      hist = {hist[2:0], sequence_out};
      if (bit_valid) begin
        if (q.size() == 0) begin
          check("unexpected_bit_valid", bit_valid, 1'b0);
        end else begin
          mon_e = q.pop_front();
          check("sequence_out", sequence_out, mon_e.b);
          check("frame_done", frame_done, mon_e.last);
          if (mon_e.zero) check("detector_hit", hist == 4'b1011, mon_e.pos == 3);
          if (mon_e.last) begin
            model_count = model_count + 8'd1;
            prev_done   = 1'b1;
          end
        end
      end else begin
        check("idle_sequence_out", sequence_out, 1'b0);
        check("idle_frame_done", frame_done, 1'b0);
      end
    end
  end

  // Stimulus-side occupancy model: remaining busy cycles of the frame in flight.
  int free_cnt = 0;

  task automatic step(input logic v, input logic [DW-1:0] d);
    logic was_free;
    @(negedge clock);
    was_free = (free_cnt == 0);
    check("load_ready", load_ready, was_free);
    check("busy", busy, !was_free);
    if (!was_free) free_cnt--;
    load_valid = v;
    load_data  = d;
    if (v && was_free) begin
      push_frame(d);
      free_cnt = L;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_sequence_out", sequence_out, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_count", frame_count, 8'd0);
    check("rst_load_ready", load_ready, 1'b1);
  endtask

  // Corner instance: DATA_W=1, GUARD_BITS=15, CNT_W=2.
  logic       c_reset = 1'b1;
  logic       c_valid = 1'b0;
  logic [0:0] c_data = '0;
  logic       c_ready, c_seq, c_bv, c_busy, c_done;
  logic [1:0] c_fc;
  logic       corner_done = 1'b0;

  serial_sequence_framer #(
    .DATA_W(1), .SYNC_PATTERN(Sync), .GUARD_BITS(15), .CNT_W(2)
  ) u_corner (
    .clock(clock), .reset(c_reset), .load_valid(c_valid), .load_data(c_data),
    .load_ready(c_ready), .sequence_out(c_seq), .bit_valid(c_bv),
    .busy(c_busy), .frame_done(c_done), .frame_count(c_fc)
  );

  initial begin
    logic       exp_b;
    logic [1:0] exp_fc;
    repeat (2) @(negedge clock);
    c_reset = 1'b0;
    for (int f = 0; f < 5; f++) begin
      @(negedge clock);
      c_valid = 1'b1;
      c_data  = 1'((f + 1) % 2);
      @(negedge clock);
      c_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (k > 0) @(negedge clock);
        if (k < 4)       exp_b = Sync[3-k];
        else if (k == 4) exp_b = 1'((f + 1) % 2);
        else             exp_b = 1'b0;
        check("corner_seq", c_seq, exp_b);
        check("corner_bit_valid", c_bv, 1'b1);
        check("corner_busy", c_busy, 1'b1);
        check("corner_frame_done", c_done, k == 19);
      end
      @(negedge clock);
      exp_fc = 2'((f + 1) % 4);
      check("corner_frame_count", c_fc, exp_fc);
      check("corner_load_ready", c_ready, 1'b1);
    end
    corner_done = 1'b1;
  end

  initial begin
    repeat (2) @(negedge clock);
    check_reset_outputs();
    #2 reset = 1'b0;

    // Reset during the 3rd payload bit (frame bit 6) of 0xFF.
    step(1'b1, 8'hFF);
    repeat (7) step(1'b0, 8'h00);
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    @(negedge clock);
    #2 reset = 1'b0;
    free_cnt = 0;
    step(1'b1, 8'h81);
    repeat (L + 1) step(1'b0, 8'h00);

    step(1'b1, 8'hA5);
    repeat (L + 1) step(1'b0, 8'h00);

    // Hold valid through the 0x3C frame; 0xFF must wait for the idle cycle.
    step(1'b1, 8'h3C);
    repeat (L + 1) step(1'b1, 8'hFF);
    repeat (L + 1) step(1'b0, 8'h00);

    step(1'b1, 8'h00);
    repeat (L + 1) step(1'b0, 8'h00);

    // Enough random traffic to wrap the 8-bit frame counter.
    repeat (5000) step($urandom_range(0, 3) != 0, DW'($urandom));
    repeat (L + 2) step(1'b0, 8'h00);

    check("queue_drained", q.size(), 0);
    check("corner_finished", corner_done, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
